inst_mem: RTL and testbench

//   Instruction memory for the single-cycle RV32I core. Maps the 32-bit PC byte address
//   to a 32-bit instruction word with zero-latency combinational read. Holds
//   NUM_OF_INST words and is preloaded at elaboration. A synchronous write port loads programs.
//   Any fetch outside the array returns a NOP (ADDI x0,x0,0 = 32'h00000013).

---
 rtl/inst_mem_pkg.sv | 18 +
 rtl/inst_mem_if.sv | 30 +++
 rtl/inst_mem.sv | 63 ++++++
 tb/tb_inst_mem.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/inst_mem_pkg.sv
// Shared RV32I definitions used by the instruction memory, its interface and benches.
package inst_mem_pkg;

    // Architectural register / instruction word width
    localparam int XLEN = 32;

    // One 32-bit instruction word
    typedef logic [XLEN-1:0] instWord_t;

    // ADDI x0,x0,0 -- the canonical RISC-V NOP
    localparam instWord_t RV_NOP = 32'h00000013;

    // Byte address to word index: the two low bits select a byte inside the word and are dropped
    function automatic logic [XLEN-1:0] wordIndex(input logic [XLEN-1:0] byteAddr);
        return byteAddr >> 2;
    endfunction

endpackage

// File: rtl/inst_mem_if.sv
// Fetch and program-load signals between a core/loader (master) and the instruction memory (slave).
interface inst_mem_if;
    import inst_mem_pkg::*;

    logic [XLEN-1:0] pc_address;
    instWord_t       instruction;
    logic            addr_fault;
    logic            we;
    logic [XLEN-1:0] waddr;
    instWord_t       wdata;

    modport master (
        output pc_address,
        output we,
        output waddr,
        output wdata,
        input  instruction,
        input  addr_fault
    );

    modport slave (
        input  pc_address,
        input  we,
        input  waddr,
        input  wdata,
        output instruction,
        output addr_fault
    );

endinterface

// File: rtl/inst_mem.sv
// Instruction memory for the single-cycle RV32I core: zero-latency combinational fetch,
// synchronous program-load write port, NOP plus fault flag for fetches outside the array.
module inst_mem
    import inst_mem_pkg::*;
#(
    parameter int        NUM_OF_INST = 1024,
    parameter instWord_t NOP_INST    = RV_NOP,
    parameter string     INIT_FILE   = ""
) (
    input  logic       clk,
    input  logic       rst,
    inst_mem_if.slave  bus
);

    // Index width only needs to cover the array; the range check uses the full 32-bit index
    localparam int              IDX_W = (NUM_OF_INST > 1) ? $clog2(NUM_OF_INST) : 1;
    localparam logic [XLEN-1:0] DEPTH = XLEN'(NUM_OF_INST);

    typedef instWord_t memArray_t [0:NUM_OF_INST-1];

    // Power-up image: everything is a NOP
    function automatic memArray_t initMemory();
        memArray_t image;
        for (int i = 0; i < NUM_OF_INST; i++) begin
            image[i] = NOP_INST;
        end
        return image;
    endfunction

    // Benches reach into this array by name as uut.memory[i]
    memArray_t memory = initMemory();

    logic [XLEN-1:0] w_rdIndex;
    logic [XLEN-1:0] w_wrIndex;
    logic            w_rdInRange;
    logic            w_wrInRange;

    // Full-width index compare so that addresses past the end never wrap onto low words
    always_comb begin
        w_rdIndex   = wordIndex(bus.pc_address);
        w_wrIndex   = wordIndex(bus.waddr);
        w_rdInRange = (w_rdIndex < DEPTH);
        w_wrInRange = (w_wrIndex < DEPTH);
    end

    // Fetch path: no clock or reset involvement, follows address and memory contents directly
    always_comb begin
        bus.instruction = NOP_INST;
        bus.addr_fault  = 1'b1;
        if (w_rdInRange) begin
            bus.instruction = memory[w_rdIndex[IDX_W-1:0]];
            bus.addr_fault  = 1'b0;
        end
    end

    // Program load: reset only blocks writes and never clears contents; out-of-range writes vanish
    always_ff @(posedge clk) begin
        if (bus.we && !rst && w_wrInRange) begin
            memory[w_wrIndex[IDX_W-1:0]] <= bus.wdata;
        end
    end

endmodule

// File: tb/tb_inst_mem.sv
// Directed bench for inst_mem: table of fetch vectors plus hand-written write/reset sequences.
module tb_inst_mem;
    import inst_mem_pkg::*;

    logic clk = 1'b0;
    logic rst;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] expInst;
        logic        expFault;
        string       name;
    } vec_t;

    vec_t vecs [10];

    inst_mem_if bus ();

    inst_mem #(
        .NUM_OF_INST (1024),
        .NOP_INST    (32'h00000013),
        .INIT_FILE   ("")
    ) uut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    // Move the fetch address and let the combinational path settle for 1 ns
    task automatic applyStimulus(input logic [31:0] pc);
        bus.pc_address = pc;
        #1;
    endtask

    // Compare fetch outputs against bench-computed expectations
    task automatic checkOutput(input string name, input logic [31:0] expInst, input logic expFault);
        checks++;
        if (bus.instruction !== expInst || bus.addr_fault !== expFault) begin
            failures++;
            $display("[TB] FAIL %s: got instruction=%08h addr_fault=%0b, expected instruction=%08h addr_fault=%0b",
                     name, bus.instruction, bus.addr_fault, expInst, expFault);
        end
    endtask

    // One write-port cycle driven from the falling edge, inputs released 1 ns after the rising edge
    task automatic writeWord(input logic [31:0] addr, input logic [31:0] data, input logic rstLevel);
        @(negedge clk);
        rst       = rstLevel;
        bus.we    = 1'b1;
        bus.waddr = addr;
        bus.wdata = data;
        @(posedge clk);
        #1;
        bus.we = 1'b0;
        rst    = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        bus.we         = 1'b0;
        bus.waddr      = 32'h0;
        bus.wdata      = 32'h0;
        bus.pc_address = 32'h10;

        vecs[0] = '{32'h0000_0000, 32'h0010_0033, 1'b0, "word0"};
        vecs[1] = '{32'h0000_0004, 32'h0020_0113, 1'b0, "word1"};
        vecs[2] = '{32'h0000_0008, 32'h0030_2193, 1'b0, "word2"};
        vecs[3] = '{32'h0000_0FFC, 32'h0040_4233, 1'b0, "word1023"};
        vecs[4] = '{32'h0000_1000, 32'h0000_0013, 1'b1, "pc1000"};
        vecs[5] = '{32'h0000_2000, 32'h0000_0013, 1'b1, "pc2000"};
        vecs[6] = '{32'h0000_0006, 32'h0020_0113, 1'b0, "misaligned6"};
        vecs[7] = '{32'h0000_0FF8, 32'h0000_0013, 1'b0, "unwritten1022"};
        vecs[8] = '{32'hFFFF_FFFC, 32'h0000_0013, 1'b1, "pcTop"};
        vecs[9] = '{32'h0000_0010, 32'h0000_0013, 1'b0, "unwritten4"};

        // Power-up image with no file is all NOP; reset held high throughout
        repeat (2) @(posedge clk);
        #1;
        checkOutput("initNop", 32'h0000_0013, 1'b0);
        rst = 1'b0;

        // Load the small program through the write port
        writeWord(32'h0000_0000, 32'h0010_0033, 1'b0);
        writeWord(32'h0000_0004, 32'h0020_0113, 1'b0);
        writeWord(32'h0000_0008, 32'h0030_2193, 1'b0);
        writeWord(32'h0000_0FFC, 32'h0040_4233, 1'b0);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].pc);
            checkOutput(vecs[i].name, vecs[i].expInst, vecs[i].expFault);
        end

        // Combinational toggle between two words
        applyStimulus(32'h0000_0000);
        checkOutput("toggle0", 32'h0010_0033, 1'b0);
        applyStimulus(32'h0000_0004);
        checkOutput("toggle4", 32'h0020_0113, 1'b0);

        // Write blocked while reset is high
        writeWord(32'h0000_0008, 32'hDEAD_BEEF, 1'b1);
        applyStimulus(32'h0000_0008);
        checkOutput("wrBlockedByRst", 32'h0030_2193, 1'b0);

        // Same write with reset low lands
        writeWord(32'h0000_0008, 32'hDEAD_BEEF, 1'b0);
        applyStimulus(32'h0000_0008);
        checkOutput("wrLands", 32'hDEAD_BEEF, 1'b0);

        // Out-of-range write dropped, must not alias onto word 0
        writeWord(32'h0000_1000, 32'hCAFE_F00D, 1'b0);
        applyStimulus(32'h0000_1000);
        checkOutput("oorWrFetch", 32'h0000_0013, 1'b1);
        applyStimulus(32'h0000_0000);
        checkOutput("oorWrNoAlias", 32'h0010_0033, 1'b0);

        // Read and write of the same word: old data before the edge, new data after
        @(negedge clk);
        bus.pc_address = 32'h0000_000C;
        bus.we         = 1'b1;
        bus.waddr      = 32'h0000_000C;
        bus.wdata      = 32'h1234_5678;
        #1;
        checkOutput("rwBeforeEdge", 32'h0000_0013, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("rwAfterEdge", 32'h1234_5678, 1'b0);
        bus.we = 1'b0;

        // Reset in the middle of a load burst leaves existing contents intact
        @(negedge clk);
        rst            = 1'b1;
        bus.we         = 1'b1;
        bus.waddr      = 32'h0000_0000;
        bus.wdata      = 32'h0000_0BAD;
        bus.pc_address = 32'h0000_0000;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstMidLoad", 32'h0010_0033, 1'b0);
        bus.we = 1'b0;
        rst    = 1'b0;
        applyStimulus(32'h0000_0008);
        checkOutput("survivesRst", 32'hDEAD_BEEF, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
